dds_sweep_ctrl: RTL and testbench



---
 rtl/dds_sweep_ctrl.sv | 156 +++++++++++++++
 tb/tb_dds_sweep_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/dds_sweep_ctrl.sv
// DDS frequency-sweep sequencer: steps the tuning word through f_start + i*f_step,
// waits a settle time per point and handshakes with the measurement block.
module dds_sweep_ctrl #(
  parameter int          Fword_width = 28,
  parameter int          Pword_width = 10,
  parameter int          SETTLE_W    = 24,
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [Fword_width-1:0] f_start,
  input  logic [Fword_width-1:0] f_step,
  input  logic [7:0]             n_steps,
  input  logic [SETTLE_W-1:0]    settle_cyc,
  input  logic [Pword_width-1:0] pha_offs,
  input  logic                   meas_done,
  output logic [Fword_width-1:0] fre_w,
  output logic [Pword_width-1:0] pha_w,
  output logic                   meas_start,
  output logic [7:0]             step_idx,
  output logic                   busy,
  output logic                   sweep_done,
  output logic                   timeout_err
);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_MEAS} state_e;

  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYC - 1);

  state_e                 state_q, state_d;
  logic [Fword_width-1:0] fre_q, fre_d, f_step_q, f_step_d;
  logic [Pword_width-1:0] pha_q, pha_d;
  logic [7:0]             idx_q, idx_d, n_steps_q, n_steps_d;
  logic [SETTLE_W-1:0]    settle_q, settle_d, cnt_q, cnt_d;
  logic [31:0]            to_q, to_d;
  logic                   busy_q, busy_d, ms_q, ms_d, sd_q, sd_d, terr_q, terr_d;
  logic                   to_hit, adv;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      fre_q     <= '0;
      f_step_q  <= '0;
      pha_q     <= '0;
      idx_q     <= '0;
      n_steps_q <= '0;
      settle_q  <= '0;
      cnt_q     <= '0;
      to_q      <= '0;
      busy_q    <= 1'b0;
      ms_q      <= 1'b0;
      sd_q      <= 1'b0;
      terr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      fre_q     <= fre_d;
      f_step_q  <= f_step_d;
      pha_q     <= pha_d;
      idx_q     <= idx_d;
      n_steps_q <= n_steps_d;
      settle_q  <= settle_d;
      cnt_q     <= cnt_d;
      to_q      <= to_d;
      busy_q    <= busy_d;
      ms_q      <= ms_d;
      sd_q      <= sd_d;
      terr_q    <= terr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    fre_d     = fre_q;
    f_step_d  = f_step_q;
    pha_d     = pha_q;
    idx_d     = idx_q;
    n_steps_d = n_steps_q;
    settle_d  = settle_q;
    cnt_d     = cnt_q;
    to_d      = to_q;
    busy_d    = busy_q;
    ms_d      = 1'b0;
    sd_d      = 1'b0;
    terr_d    = terr_q;
    to_hit    = (to_q == TO_LAST);
    adv       = meas_done || to_hit;

    if (abort) begin
      // step_idx and timeout_err are left as-is so software can see where it stopped
      state_d = S_IDLE;
      fre_d   = '0;
      pha_d   = '0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            terr_d = 1'b0;
            if (n_steps != 8'd0) begin
              f_step_d  = f_step;
              n_steps_d = n_steps;
              settle_d  = settle_cyc;
              cnt_d     = settle_cyc;
              fre_d     = f_start;
              pha_d     = pha_offs;
              idx_d     = 8'd0;
              busy_d    = 1'b1;
              state_d   = S_SETTLE;
            end else begin
              sd_d = 1'b1;
            end
          end
        end
        S_SETTLE: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else begin
            ms_d    = 1'b1;
            to_d    = '0;
            state_d = S_MEAS;
          end
        end
        S_MEAS: begin
          // a meas_done landing on the timeout edge wins: no error recorded
          if (to_hit && !meas_done) terr_d = 1'b1;
          if (!adv) begin
            to_d = to_q + 32'd1;
          end else if (idx_q == n_steps_q - 8'd1) begin
            fre_d   = '0;
            pha_d   = '0;
            busy_d  = 1'b0;
            sd_d    = 1'b1;
            state_d = S_IDLE;
          end else begin
            fre_d   = fre_q + f_step_q;
            idx_d   = idx_q + 8'd1;
            cnt_d   = settle_q;
            state_d = S_SETTLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign fre_w       = fre_q;
  assign pha_w       = pha_q;
  assign meas_start  = ms_q;
  assign step_idx    = idx_q;
  assign busy        = busy_q;
  assign sweep_done  = sd_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Randomized bench for dds_sweep_ctrl against a timeline model of each sweep.
module tb_dds_sweep_ctrl;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst, start, abort, meas_done;
  logic [27:0] f_start, f_step, fre_w;
  logic [7:0]  n_steps, step_idx;
  logic [23:0] settle_cyc;
  logic [9:0]  pha_offs, pha_w;
  logic        meas_start, busy, sweep_done, timeout_err;

  int checks = 0, errors = 0;

  // timeline of the current sweep: u[i] = edge point i's word is loaded,
  // m[i] = edge raising meas_start, dn[i] = edge meas_done is driven (-1: never)
  int          u [0:16];
  int          m [0:15];
  int          dn[0:15];
  bit          to[0:15];
  logic [27:0] cfs, cstep;
  logic [9:0]  cpha;
  int          cn, prev_idx;
  bit          prev_err;

  dds_sweep_ctrl #(.Fword_width(28), .Pword_width(10), .SETTLE_W(24), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .f_start(f_start), .f_step(f_step),
    .n_steps(n_steps), .settle_cyc(settle_cyc), .pha_offs(pha_offs), .meas_done(meas_done),
    .fre_w(fre_w), .pha_w(pha_w), .meas_start(meas_start), .step_idx(step_idx), .busy(busy),
    .sweep_done(sweep_done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic void sweep_at(input int c, output int idx, output bit err,
                                   output logic [27:0] fre, output bit bsy, output bit ms, output bit sd);
    if (c < 0) begin
      idx = prev_idx; err = prev_err; fre = '0; bsy = 0; ms = 0; sd = 0;
      return;
    end
    err = 0; ms = 0;
    for (int i = 0; i < cn; i++) begin
      if (to[i] && u[i+1] <= c) err = 1;
      if (m[i] == c) ms = 1;
    end
    sd = (c == u[cn]);
    if (c >= u[cn]) begin
      bsy = 0; fre = '0;
      idx = (cn == 0) ? prev_idx : cn - 1;
    end else begin
      idx = 0;
      for (int i = 0; i < cn; i++) if (u[i] <= c) idx = i;
      bsy = 1;
      fre = cfs + 28'(idx) * cstep;
    end
  endfunction

  function automatic void expect_at(input int c, input int ab, output int idx, output bit err,
                                    output logic [27:0] fre, output bit bsy, output bit ms, output bit sd);
    sweep_at(c, idx, err, fre, bsy, ms, sd);
    if (ab >= 0 && c >= ab) begin
      sweep_at(ab - 1, idx, err, fre, bsy, ms, sd);
      fre = '0; bsy = 0; ms = 0; sd = 0;
    end
  endfunction

  task automatic idle_inputs();
    start = 0; abort = 0; meas_done = 0;
    f_start = '0; f_step = '0; n_steps = '0; settle_cyc = '0; pha_offs = '0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_fre"}, fre_w, 0);
    chk({tag, "_pha"}, pha_w, 0);
    chk({tag, "_idx"}, step_idx, 0);
    chk({tag, "_ctl"}, {meas_start, busy, sweep_done, timeout_err}, 0);
  endtask

  // lat < 0: random measurement latency per point; lat > TO: meas_done never comes
  task automatic run(input logic [27:0] fs, input logic [27:0] st, input int n, input int s,
                     input logic [9:0] ph, input int lat, input int ab);
    int l, last, idx;
    bit err, bsy, ms, sd, md;
    logic [27:0] fre;
    cfs = fs; cstep = st; cn = n; cpha = ph; u[0] = 0;
    for (int i = 0; i < n; i++) begin
      l = (lat < 0) ? int'($urandom_range(1, 20)) : lat;
      m[i] = u[i] + s + 1;
      if (l <= TO) begin dn[i] = m[i] + l; u[i+1] = m[i] + l; to[i] = 0; end
      else         begin dn[i] = -1;       u[i+1] = m[i] + TO; to[i] = 1; end
    end
    last = u[n] + 2;
    for (int c = 0; c <= last; c++) begin
      if (c == 0) begin
        start = 1; f_start = fs; f_step = st; n_steps = 8'(n);
        settle_cyc = 24'(s); pha_offs = ph; meas_done = 0;
      end else begin
        start = (ab < 0 || c < ab) && c <= u[n] && ($urandom_range(0, 5) == 0);
        f_start = 28'($urandom); f_step = 28'($urandom); n_steps = 8'($urandom_range(1, 255));
        settle_cyc = 24'($urandom_range(0, 9)); pha_offs = 10'($urandom);
        md = 0;
        for (int i = 0; i < n; i++) begin
          if (dn[i] == c) md = 1;
          if (c >= u[i] + 1 && c <= u[i] + s + 1 && $urandom_range(0, 3) == 0) md = 1;
        end
        if (c > u[n] && $urandom_range(0, 3) == 0) md = 1;
        meas_done = md;
      end
      abort = (c == ab);
      @(posedge clk);
      @(negedge clk);
      start = 0; abort = 0; meas_done = 0;
      expect_at(c, ab, idx, err, fre, bsy, ms, sd);
      chk("fre", fre_w, fre);
      chk("pha", pha_w, bsy ? cpha : 10'd0);
      chk("idx", step_idx, 8'(idx));
      chk("busy", busy, bsy);
      chk("mstart", meas_start, ms);
      chk("sdone", sweep_done, sd);
      chk("terr", timeout_err, err);
    end
    prev_idx = idx; prev_err = err;
  endtask

  initial begin
    bit seen;
    idle_inputs();
    rst = 1;
    prev_idx = 0; prev_err = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    rst = 0;
    @(negedge clk);

    run(28'd1000, 28'd500, 4, 3, 10'h155, 5, -1);           // basic sweep
    run(28'hFFFFF00, 28'h200, 2, 2, 10'h0AA, 3, -1);        // tuning word wraps
    run(28'd77, 28'd9, 3, 2, 10'h3FF, 99, -1);              // every point times out
    run(28'd5, 28'd5, 0, 1, 10'h001, 1, -1);                // n_steps=0, clears error
    run(28'd7, 28'd3, 2, 1, 10'h002, 99, -1);
    run(28'd8, 28'd4, 3, 1, 10'h003, 2, 0);                 // start+abort: nothing starts
    run(28'd2000, 28'd100, 4, 5, 10'h123, 3, 20);           // abort in SETTLE of point 2
    run(28'd10, 28'd1, 2, 0, 10'h010, 16, -1);              // done on the timeout edge
    run(28'd11, 28'd1, 2, 0, 10'h011, 17, -1);              // one past: timeout

    for (int k = 0; k < 25; k++) begin
      int ab, n, s;
      n = $urandom_range(0, 6);
      s = $urandom_range(0, 6);
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, n * (s + 17) + 1)) : -1;
      run(28'($urandom), 28'($urandom), n, s, 10'($urandom), -1, ab);
    end

    // reset while waiting for meas_done
    start = 1; f_start = 28'd123; f_step = 28'd1; n_steps = 8'd3; settle_cyc = 24'd2; pha_offs = 10'h2A;
    @(posedge clk);
    @(negedge clk);
    start = 0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = meas_start;
    end
    chk("mstart_wait", seen, 1);
    @(negedge clk);
    rst = 1;
    @(posedge clk);
    @(negedge clk);
    chk_zero("rst_meas");
    rst = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
